// File: rtl/mem_dispatch.sv
// mem_dispatch: reads N_PE*WPP words from a synchronous memory and sends each
// one as a NoC packet {dest, widx, data}. A run starts on a start token from the
// control center and ends with a done token.
//
// Build option: define MEM_DISPATCH_PARITY_EN to add an even-parity MSB to
// pkt_data (XOR of all other packet bits).
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cc_start_valid/cc_start_ready   start token handshake (accepted only in IDLE)
//   cc_done_valid/cc_done_ready     done token handshake (offered only in DONE)
//   mem_addr, mem_rdata             memory read port, data one cycle after address
//   pkt_valid/pkt_ready, pkt_data   NoC packet output
//
// state | meaning
// IDLE  | waiting for a start token
// READ  | mem_addr presents the current word address
// LOAD  | mem_rdata captured into the packet register
// SEND  | packet offered to the NoC until accepted
// DONE  | done token offered to the control center
module mem_dispatch #(
  parameter int N_PE   = 9,
  parameter int WPP    = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  localparam int BODY_W = 4 + ADDR_W + DATA_W,
`ifdef MEM_DISPATCH_PARITY_EN
  localparam int PKT_W = BODY_W + 1
`else
  localparam int PKT_W = BODY_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cc_start_valid,
  output logic              cc_start_ready,
  output logic              cc_done_valid,
  input  logic              cc_done_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PKT_W-1:0]  pkt_data
);

  localparam int PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int W_W  = (WPP > 1) ? $clog2(WPP) : 1;

  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, DONE} state_t;

  state_t            state, state_nx;
  logic [PE_W-1:0]   pe_cnt;
  logic [W_W-1:0]    w_cnt;
  // Running linear address; equals pe_cnt*WPP + w_cnt without a multiplier.
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [PKT_W-1:0]  pkt_q;
  logic [BODY_W-1:0] pkt_body;
  logic              last_word;
  logic              pkt_hs;

  assign last_word = (pe_cnt == PE_W'(N_PE - 1)) && (w_cnt == W_W'(WPP - 1));
  assign pkt_hs    = (state == SEND) && pkt_ready;
  assign pkt_body  = {4'(pe_cnt), ADDR_W'(w_cnt), mem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cc_start_valid) state_nx = READ;
      READ:    state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (pkt_ready) state_nx = last_word ? DONE : READ;
      DONE:    if (cc_done_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cc_start_ready is gated by reset so it reads 0 for as long as reset is high.
  always_comb begin
    cc_start_ready = (state == IDLE) && !reset;
    cc_done_valid  = (state == DONE);
    pkt_valid      = (state == SEND);
    mem_addr       = (state == READ) ? addr_cnt : mem_addr_q;
    pkt_data       = (state == SEND) ? pkt_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_cnt     <= '0;
      w_cnt      <= '0;
      addr_cnt   <= '0;
      mem_addr_q <= '0;
      pkt_q      <= '0;
    end else begin
      if (state == IDLE && cc_start_valid) begin
        pe_cnt   <= '0;
        w_cnt    <= '0;
        addr_cnt <= '0;
      end
      if (state == READ) mem_addr_q <= addr_cnt;
      if (state == LOAD) begin
`ifdef MEM_DISPATCH_PARITY_EN
        pkt_q <= {^pkt_body, pkt_body};
`else
        pkt_q <= pkt_body;
`endif
      end
      if (pkt_hs) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
        if (w_cnt == W_W'(WPP - 1)) begin
          w_cnt  <= '0;
          pe_cnt <= pe_cnt + PE_W'(1);
        end else begin
          w_cnt <= w_cnt + W_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_dispatch.sv
module tb_mem_dispatch;

  localparam int N_PE   = 9;
  localparam int WPP    = 5;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int BODY_W = 4 + ADDR_W + DATA_W;
`ifdef MEM_DISPATCH_PARITY_EN
  localparam int PKT_W = BODY_W + 1;
`else
  localparam int PKT_W = BODY_W;
`endif
  localparam int N_WORDS = N_PE * WPP;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cc_start_valid = 1'b0;
  logic              cc_start_ready;
  logic              cc_done_valid;
  logic              cc_done_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              pkt_valid;
  logic              pkt_ready = 1'b1;
  logic [PKT_W-1:0]  pkt_data;

  logic [DATA_W-1:0] tb_mem [0:255];

  int total = 0;
  int bad   = 0;

  mem_dispatch #(
    .N_PE(N_PE), .WPP(WPP), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cc_start_valid(cc_start_valid),
    .cc_start_ready(cc_start_ready),
    .cc_done_valid(cc_done_valid),
    .cc_done_ready(cc_done_ready),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_data(pkt_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for an address appears one cycle later.
  always @(posedge clk) mem_rdata <= tb_mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] exp_pkt(input int k);
    logic [BODY_W-1:0] b;
    b = {4'(k / WPP), 8'(k % WPP), tb_mem[k]};
`ifdef MEM_DISPATCH_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  // Called at a negedge in the start cycle's IDLE state; returns at the READ negedge.
  task automatic do_start();
    cc_start_valid = 1'b1;
    @(negedge clk);
    cc_start_valid = 1'b0;
    chk("start_ready_busy", cc_start_ready, 1'b0);
  endtask

  // Receives packets 0..n-1, entering and leaving at a READ (or DONE) negedge.
  task automatic recv(input int n, input int stall_pkt, input int stall_len, input int poke_pkt);
    int waits;
    for (int k = 0; k < n; k++) begin
      pkt_ready = (k == stall_pkt) ? 1'b0 : 1'b1;
      chk($sformatf("addr_read%0d", k), mem_addr, k);
      waits = 0;
      while (!pkt_valid && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      chk($sformatf("latency%0d", k), waits, 2);
      chk($sformatf("pkt%0d", k), pkt_data, exp_pkt(k));
      chk($sformatf("addr_hold%0d", k), mem_addr, k);
`ifdef MEM_DISPATCH_PARITY_EN
      // tb_mem[7] is 0x03: body {1, 2, 0x03} has four ones, so the XOR bit is 0.
      if (k == 7) chk("parity_k7", pkt_data, {1'b0, 4'd1, 8'd2, 8'h03});
`endif
      if (k == poke_pkt) begin
        cc_start_valid = 1'b1;
        chk("poke_start_ready", cc_start_ready, 1'b0);
      end
      if (k == stall_pkt) begin
        for (int i = 1; i < stall_len; i++) begin
          @(negedge clk);
          chk($sformatf("stall_valid%0d", i), pkt_valid, 1'b1);
          chk($sformatf("stall_data%0d", i), pkt_data, exp_pkt(k));
        end
      end
      pkt_ready = 1'b1;
      @(negedge clk);
      cc_start_valid = 1'b0;
    end
  endtask

  // Entered at the DONE negedge.
  task automatic finish_done(input int delay);
    chk("done_valid", cc_done_valid, 1'b1);
    chk("done_pkt_valid", pkt_valid, 1'b0);
    for (int i = 0; i < delay; i++) begin
      cc_done_ready = 1'b0;
      chk($sformatf("done_hold%0d", i), cc_done_valid, 1'b1);
      chk($sformatf("done_start_ready%0d", i), cc_start_ready, 1'b0);
      @(negedge clk);
    end
    cc_done_ready = 1'b1;
    chk("done_before_hs", cc_done_valid, 1'b1);
    @(negedge clk);
    cc_done_ready = 1'b0;
    chk("idle_done_valid", cc_done_valid, 1'b0);
    chk("idle_start_ready", cc_start_ready, 1'b1);
    @(negedge clk);
    chk("single_done", cc_done_valid, 1'b0);
  endtask

  initial begin
    int waits;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i + 16);
`ifdef MEM_DISPATCH_PARITY_EN
    tb_mem[7] = 8'h03;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_start_ready", cc_start_ready, 1'b0);
    chk("rst_done_valid", cc_done_valid, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pkt_data", pkt_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", cc_start_ready, 1'b1);

    // Run 1: full stream, done_ready held high throughout (ignored until DONE)
    cc_done_ready = 1'b1;
    do_start();
    recv(N_WORDS, -1, 0, -1);
    finish_done(0);

    // Run 2: 10-cycle stall on packet 7, start token poked during packet 12
    do_start();
    recv(N_WORDS, 7, 10, 12);
    finish_done(0);

    // Run 3: reset while packet 21 is being offered
    do_start();
    recv(21, -1, 0, -1);
    waits = 0;
    while (!pkt_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("abort_reach_send", pkt_valid, 1'b1);
    chk("abort_addr_before", mem_addr, 21);
    reset = 1'b1;
    #1;
    chk("abort_pkt_valid", pkt_valid, 1'b0);
    chk("abort_pkt_data", pkt_data, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_start_ready", cc_start_ready, 1'b0);
    chk("abort_done_valid", cc_done_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_hold_start_ready", cc_start_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_release_start_ready", cc_start_ready, 1'b1);
    @(negedge clk);
    chk("abort_no_done", cc_done_valid, 1'b0);

    // Run 4: fresh run after abort, done_ready held low for 5 DONE cycles
    do_start();
    recv(N_WORDS, -1, 0, -1);
    finish_done(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
